// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: walk / bounce / binary / fill patterns, stepped by a
// debounced key edge or a prescaled tick, with run/pause control.
// Bounce direction FSM: state    | meaning
//                       DIR_UP   | bounce position counting up
//                       DIR_DOWN | bounce position counting down
module led_pattern_seq #(
  parameter int NUM_LEDS = 8,
  parameter int TICK_DIV = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_n,
  input  logic                auto_en,
  input  logic [1:0]          mode,
  input  logic                start,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] pos,
  output logic                running,
  output logic                wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]       PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]       PRESC_ONE = PW'(1);
  localparam logic [NUM_LEDS-1:0] POS_ONE   = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] POS_LAST  = NUM_LEDS'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] POS_FULL  = NUM_LEDS'(NUM_LEDS);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  dir_t                dir, dir_d;
  logic [1:0]          mode_q, mode_d;
  logic [NUM_LEDS-1:0] pos_d, led_d;
  logic [PW-1:0]       presc, presc_d;
  logic                running_d, wrap_d;
  logic                key_s1, key_s2, key_s3;
  logic                fall, tick, adv;

  // LED image for a given pattern and step index
  function automatic logic [NUM_LEDS-1:0] pattern(input logic [1:0] m,
                                                  input logic [NUM_LEDS-1:0] p);
    logic [NUM_LEDS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (m)
        2'd0:    r[i] = (p == NUM_LEDS'(i + 1));
        2'd1:    r[i] = (p == NUM_LEDS'(i));
        2'd2:    r[i] = p[i];
        default: r[i] = (NUM_LEDS'(i) < p);
      endcase
    end
    return r;
  endfunction

  assign fall = key_s3 & ~key_s2;
  assign tick = running & auto_en & (presc == PRESC_MAX);
  assign adv  = running & (auto_en ? tick : fall);

  always_comb begin
    mode_d    = mode_q;
    pos_d     = pos;
    dir_d     = dir;
    presc_d   = presc;
    wrap_d    = 1'b0;
    running_d = start ? 1'b1 : (pause ? 1'b0 : running);

    if (running && auto_en)
      presc_d = tick ? '0 : presc + PRESC_ONE;

    // a mode change restarts the new pattern and swallows any advance
    if (mode != mode_q) begin
      mode_d  = mode;
      pos_d   = '0;
      dir_d   = DIR_UP;
      presc_d = '0;
    end else if (adv) begin
      case (mode_q)
        2'd1: begin
          if (dir == DIR_UP) begin
            if (pos == POS_LAST) begin
              pos_d  = pos - POS_ONE;
              dir_d  = DIR_DOWN;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos + POS_ONE;
            end
          end else begin
            if (pos == '0) begin
              pos_d  = POS_ONE;
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos - POS_ONE;
            end
          end
        end
        2'd2: begin
          pos_d  = pos + POS_ONE;
          wrap_d = &pos;
        end
        default: begin
          if (pos >= POS_FULL) begin
            pos_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos + POS_ONE;
          end
        end
      endcase
    end

    led_d = pattern(mode_d, pos_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1  <= 1'b1;
      key_s2  <= 1'b1;
      key_s3  <= 1'b1;
      mode_q  <= '0;
      pos     <= '0;
      led     <= '0;
      dir     <= DIR_UP;
      presc   <= '0;
      running <= 1'b1;
      wrap    <= 1'b0;
    end else begin
      key_s1  <= key_n;
      key_s2  <= key_s1;
      key_s3  <= key_s2;
      mode_q  <= mode_d;
      pos     <= pos_d;
      led     <= led_d;
      dir     <= dir_d;
      presc   <= presc_d;
      running <= running_d;
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: directed scenarios plus random stimulus, compared
// every cycle against an index/phase based reference model.
module tb_led_pattern_seq;

  localparam int N   = 8;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_n;
  logic         auto_en;
  logic [1:0]   mode;
  logic         start;
  logic         pause;
  logic [N-1:0] led;
  logic [N-1:0] pos;
  logic         running;
  logic         wrap;

  int n_checks = 0;
  int n_errors = 0;

  led_pattern_seq #(.NUM_LEDS(N), .TICK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .auto_en(auto_en), .mode(mode),
    .start(start), .pause(pause), .led(led), .pos(pos), .running(running),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Reference model: m_idx is the step index (bounce uses a 0..2N-3 phase)
  int m_mode = 0;
  int m_idx  = 0;
  int m_cnt  = 0;
  bit m_down = 0;
  bit m_run  = 1;
  bit m_wrap = 0;
  int key_hist[$] = '{1, 1, 1};

  function automatic int exp_pos();
    if (m_mode == 1) return (m_idx < N) ? m_idx : 2*N - 2 - m_idx;
    return m_idx;
  endfunction

  function automatic int exp_led();
    int p;
    p = exp_pos();
    case (m_mode)
      0:       return (p == 0) ? 0 : (1 << (p - 1));
      1:       return 1 << p;
      2:       return p;
      default: return (1 << p) - 1;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_idx = 0; m_cnt = 0; m_down = 0; m_run = 1; m_wrap = 0;
      key_hist = '{1, 1, 1};
    end else begin
      bit tick, fall, adv;
      tick = m_run && auto_en && (m_cnt == DIV - 1);
      fall = (key_hist[1] == 0) && (key_hist[2] == 1);
      key_hist.push_front(int'(key_n));
      void'(key_hist.pop_back());
      adv = m_run && (auto_en ? tick : fall);
      m_wrap = 0;
      if (m_run && auto_en) m_cnt = tick ? 0 : m_cnt + 1;
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode); m_idx = 0; m_down = 0; m_cnt = 0;
      end else if (adv) begin
        case (m_mode)
          1: begin
            m_wrap = (m_idx == N - 1) || (m_idx == 0 && m_down);
            m_idx  = (m_idx + 1) % (2*N - 2);
            if (m_idx == 0) m_down = 1;
          end
          2: begin
            m_wrap = (m_idx == (1 << N) - 1);
            m_idx  = (m_idx + 1) % (1 << N);
          end
          default: begin
            m_wrap = (m_idx == N);
            m_idx  = (m_idx + 1) % (N + 1);
          end
        endcase
      end
      if (start) m_run = 1;
      else if (pause) m_run = 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (reset) begin
      check_val("pos", 32'(pos), exp_pos());
      check_val("led", 32'(led), exp_led());
      check_val("running", 32'(running), 32'(m_run));
      check_val("wrap", 32'(wrap), 32'(m_wrap));
    end
  endtask

  initial begin
    bit reached;
    reset = 1'b0; key_n = 1'b1; auto_en = 1'b0; mode = 2'd0; start = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_pos", 32'(pos), 0);
    check_val("rst_led", 32'(led), 0);
    check_val("rst_running", 32'(running), 1);
    check_val("rst_wrap", 32'(wrap), 0);
    reset = 1'b1;
    repeat (2) cyc();

    // manual walk: nine presses return to all-off
    repeat (9) begin
      key_n = 1'b0; repeat (3) cyc();
      key_n = 1'b1; repeat (3) cyc();
    end
    check_val("walk_end_pos", 32'(pos), 0);

    // long hold gives exactly one step
    key_n = 1'b0; repeat (20) cyc();
    key_n = 1'b1; repeat (5) cyc();
    check_val("hold_one_step", 32'(pos), 1);

    // auto bounce
    mode = 2'd1; auto_en = 1'b1;
    repeat (60) cyc();

    // auto binary, pause at 5
    mode = 2'd2;
    for (int i = 0; i < 200 && !(m_mode == 2 && m_idx == 5); i++) cyc();
    reached = (m_mode == 2 && m_idx == 5);
    check_val("reach_bin5", 32'(reached), 1);
    pause = 1'b1; repeat (20) cyc();
    check_val("pause_hold", 32'(led), 5);
    start = 1'b1; cyc();
    check_val("start_wins", 32'(running), 1);
    start = 1'b0; pause = 1'b0;
    repeat (4) cyc();
    check_val("resume_step", 32'(led), 6);

    // mode change while paused at 200
    for (int i = 0; i < 1000 && !(m_mode == 2 && m_idx == 200); i++) cyc();
    reached = (m_mode == 2 && m_idx == 200);
    check_val("reach_bin200", 32'(reached), 1);
    pause = 1'b1; cyc(); pause = 1'b0;
    mode = 2'd3; cyc();
    check_val("mchg_pos", 32'(pos), 0);
    check_val("mchg_led", 32'(led), 0);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (12) cyc();
    check_val("fill_3", 32'(led), 7);

    // async reset mid-bounce while moving down through pos 4
    mode = 2'd1;
    for (int i = 0; i < 300 && !(m_mode == 1 && m_idx == 10); i++) cyc();
    reached = (m_mode == 1 && m_idx == 10);
    check_val("reach_bounce_dn4", 32'(reached), 1);
    #2 reset = 1'b0;
    #1;
    check_val("arst_pos", 32'(pos), 0);
    check_val("arst_led", 32'(led), 0);
    check_val("arst_running", 32'(running), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) cyc();
    check_val("arst_first_tick", 32'(pos), 1);

    // random mix
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
      start = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) key_n = ~key_n;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
